rr_arbiter4: RTL



---
 rtl/rr_arbiter4_pkg.sv | 18 +
 rtl/rr_arbiter4_enc2to4.sv | 23 ++
 rtl/rr_arbiter4.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   N_REQ   - number of requesters
//   IDX_W   - width of a requester index
//   state_t - arbiter grant state (IDLE / GRANT)
// ---------------------------------------------------------------------------
package rr_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_arbiter4_pkg

// File: rtl/rr_arbiter4_enc2to4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4_enc2to4
// The Encoder2to4 binary-to-one-hot decoder: converts a 2-bit index into a
// 4-bit one-hot vector. Purely combinational.
// Ports:
//   i_idx    [IDX_W-1:0]  binary index
//   o_onehot [N_REQ-1:0]  one-hot decode of i_idx
// ---------------------------------------------------------------------------
module rr_arbiter4_enc2to4
  import rr_arbiter4_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_REQ-1:0] o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dec
      assign o_onehot[gi] = (i_idx == IDX_W'(gi));
    end
  endgenerate

endmodule : rr_arbiter4_enc2to4

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter for a single shared resource. A rotating
// priority pointer selects the winner in IDLE; the winner keeps the grant
// until it drops its request (no preemption). All outputs are registered.
//
// Optional feature (macro RR_ARBITER4_TIMEOUT_EN): an 8-bit hold counter
// revokes a grant after MAX_HOLD cycles and pulses timeout for one cycle.
// Without the macro, timeout is tied low and grants last indefinitely.
//
// Parameters:
//   MAX_HOLD  maximum grant length in cycles (2..255), timeout build only
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   req      [3:0] request lines, held high for the whole transaction
//   gnt      [3:0] one-hot grant, all-zero when idle
//   gnt_id   [1:0] index of the current or most recent owner
//   busy     high while a grant is active
//   timeout  one-cycle pulse when a grant is forcibly revoked
// ---------------------------------------------------------------------------
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             busy,
  output logic             timeout
);

  // Hold-counter value seen at the last permitted grant cycle.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W-1:0] r_gnt_id;
  logic [IDX_W-1:0] w_gnt_id_next;
  logic [N_REQ-1:0] w_dec;

  // First set request in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Scanning from the farthest offset down lets the nearest hit win last.
  function automatic logic [IDX_W-1:0] f_pick(input logic [N_REQ-1:0] rq,
                                              input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    f_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (rq[idx]) f_pick = idx;
    end
  endfunction

`ifdef RR_ARBITER4_TIMEOUT_EN
  logic [7:0] r_hold;
  logic [7:0] w_hold_next;
  logic       r_timeout;
  logic       w_timeout_next;
`else
  logic       w_unused_cfg;
  assign w_unused_cfg = ^HOLD_LAST;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_gnt_id_next = r_gnt_id;
`ifdef RR_ARBITER4_TIMEOUT_EN
    w_timeout_next = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_gnt_id_next = f_pick(req, r_ptr);
          w_state_next  = GRANT;
        end
      end
      GRANT: begin
        if (!req[r_gnt_id]) begin
          // Voluntary release: the old owner drops to lowest priority.
          w_ptr_next   = r_gnt_id + IDX_W'(1);
          w_state_next = IDLE;
        end
`ifdef RR_ARBITER4_TIMEOUT_EN
        else if (r_hold == HOLD_LAST) begin
          w_ptr_next     = r_gnt_id + IDX_W'(1);
          w_state_next   = IDLE;
          w_timeout_next = 1'b1;
        end
`endif
      end
      default: w_state_next = IDLE;
    endcase
`ifdef RR_ARBITER4_TIMEOUT_EN
    // Counts completed GRANT cycles; zero whenever a new grant starts.
    w_hold_next = (r_state == GRANT && w_state_next == GRANT) ? r_hold + 8'd1 : 8'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_gnt_id <= w_gnt_id_next;
    end
  end

`ifdef RR_ARBITER4_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= w_hold_next;
      r_timeout <= w_timeout_next;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  rr_arbiter4_enc2to4 u_dec (
    .i_idx    (r_gnt_id),
    .o_onehot (w_dec)
  );

  // gnt_id persists through IDLE, so the decode is masked by busy.
  assign busy   = (r_state == GRANT);
  assign gnt    = w_dec & {N_REQ{busy}};
  assign gnt_id = r_gnt_id;

endmodule : rr_arbiter4
